// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the registered ALU (alu_seq).
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_DIV = 4'h8;
  localparam logic [3:0] OP_REM = 4'h9;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiply or restoring divide, WIDTH steps.
// The first step is taken on the start edge, so done is raised WIDTH cycles after start.
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, div_q, div_d;

  logic [WIDTH-1:0] src_hi, src_lo, src_b;
  logic             src_div, step, ge;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff, nxt_hi, nxt_lo;

  always_comb begin
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? a : lo_q;
    src_b   = start ? b : b_q;
    src_div = start ? is_div : div_q;
    // hi holds the running partial product / partial remainder, lo the multiplier / quotient
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    shifted = {src_hi, src_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, src_b};
    diff    = shifted[WIDTH-1:0] - src_b;
    if (src_div) begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {src_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], src_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    step  = start || (run_q && cnt_q != '0);
    done  = run_q && cnt_q == '0;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      hi_d  = nxt_hi;
      lo_d  = nxt_lo;
      b_d   = b;
      div_d = is_div;
      cnt_d = CW'(WIDTH - 1);
      run_d = 1'b1;
    end else if (step) begin
      hi_d  = nxt_hi;
      lo_d  = nxt_lo;
      cnt_d = cnt_q - CW'(1);
    end else if (done) begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quot    = lo_q;
  assign prod_lo = lo_q;
  assign rem     = hi_q;
  assign prod_hi = hi_q;
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and multi-cycle MUL/DIV.
// Define ALU_SEQ_REM_EN to enable op 1001 (REM) from the shared divider.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic             un,
  output logic             err,
  output logic             zero,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] W_VAL = (WIDTH + 1)'(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             of_q, of_d, un_q, un_d, err_q, err_d, zero_q, zero_d;

  logic             accept, is_multi, b_big, iter_done;
  logic [WIDTH:0]   add_full;
  logic [2*WIDTH-1:0] shl_full;
  logic [WIDTH-1:0] sc_out;
  logic             sc_of, sc_un, sc_err;
  logic [WIDTH-1:0] quot, rem, prod_lo, prod_hi;

  assign accept = in_valid && in_ready;

  always_comb begin
    is_multi = (op == OP_MUL) || (op == OP_DIV && b != '0);
`ifdef ALU_SEQ_REM_EN
    is_multi = is_multi || (op == OP_REM && b != '0);
`endif
  end

  // Single-cycle results, computed straight from the inputs and registered on acceptance
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    shl_full = {{WIDTH{1'b0}}, a} << b[SHW-1:0];
    b_big    = {1'b0, b} >= W_VAL;
    sc_out   = '0;
    sc_of    = 1'b0;
    sc_un    = 1'b0;
    sc_err   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_out = add_full[WIDTH-1:0];
        sc_of  = add_full[WIDTH];
      end
      OP_SUB: begin
        sc_out = a - b;
        sc_un  = a < b;
      end
      OP_AND: sc_out = a & b;
      OP_OR:  sc_out = a | b;
      OP_XOR: sc_out = a ^ b;
      OP_SHL: begin
        sc_out = b_big ? '0 : shl_full[WIDTH-1:0];
        sc_of  = b_big ? (a != '0) : (shl_full[2*WIDTH-1:WIDTH] != '0);
      end
      OP_SHR: sc_out = b_big ? '0 : (a >> b[SHW-1:0]);
      OP_DIV: begin
        sc_out = '1;
        sc_err = 1'b1;
      end
`ifdef ALU_SEQ_REM_EN
      OP_REM: begin
        sc_out = a;
        sc_err = 1'b1;
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_multi),
    .is_div  (op != OP_MUL),
    .a       (a),
    .b       (b),
    .done    (iter_done),
    .quot    (quot),
    .rem     (rem),
    .prod_lo (prod_lo),
    .prod_hi (prod_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      out_q   <= '0;
      of_q    <= 1'b0;
      un_q    <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      of_q    <= of_d;
      un_q    <= un_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    of_d    = of_q;
    un_d    = un_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = op;
        if (is_multi) begin
          state_d = ITER;
        end else begin
          state_d = DONE;
          out_d   = sc_out;
          of_d    = sc_of;
          un_d    = sc_un;
          err_d   = sc_err;
        end
      end
      ITER: if (iter_done) begin
        state_d = DONE;
        // Only MUL, DIV and (when enabled) REM ever reach ITER
        out_d   = (op_q == OP_MUL) ? prod_lo : ((op_q == OP_DIV) ? quot : rem);
        of_d    = (op_q == OP_MUL) && (prod_hi != '0);
        un_d    = 1'b0;
        err_d   = 1'b0;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    zero_d = (out_d == '0) && !err_d;
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == ITER);
    out_valid = (state_q == DONE);
    zero      = zero_q && out_valid;
  end

  assign out = out_q;
  assign of  = of_q;
  assign un  = un_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan cases, async reset abort, random ops.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid, of, un, err, zero, busy;
  logic [W-1:0] dout;

  int total = 0;
  int bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .of        (of),
    .un        (un),
    .err       (err),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the op definitions, using plain integer arithmetic
  function automatic void model(input int o, input longint x, input longint y,
                                output longint r, output int f_of, output int f_un,
                                output int f_err, output int lat);
    longint m = longint'(1) << W;
    longint p;
    r = 0; f_of = 0; f_un = 0; f_err = 0; lat = 1;
    case (o)
      0: begin r = (x + y) % m; f_of = int'(x + y >= m); end
      1: begin r = (x - y + m) % m; f_un = int'(x < y); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: if (y >= W) begin r = 0; f_of = int'(x != 0); end
         else begin p = x * (longint'(1) << y); r = p % m; f_of = int'(p >= m); end
      6: r = (y >= W) ? 0 : x / (longint'(1) << y);
      7: begin p = x * y; r = p % m; f_of = int'(p >= m); lat = W + 1; end
      8: if (y == 0) begin r = m - 1; f_err = 1; end else begin r = x / y; lat = W + 1; end
`ifdef ALU_SEQ_REM_EN
      9: if (y == 0) begin r = x; f_err = 1; end else begin r = x % y; lat = W + 1; end
`endif
      default: f_err = 1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int hold);
    longint r;
    int e_of, e_un, e_err, e_lat, lat, busy_cnt, rdy_viol, guard;
    model(int'(o), longint'(xa), longint'(xb), r, e_of, e_un, e_err, e_lat);
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1; op = o; a = xa; b = xb; out_ready = 1'b0;
    @(negedge clk);
    // Keep requesting with junk operands: they must be ignored while not ready
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1; busy_cnt = 0; rdy_viol = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_viol++;
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("busy_cycles", busy_cnt, e_lat - 1);
    chk("in_ready_while_busy", rdy_viol, 0);
    $display("txn op=%h a=%h b=%h -> out=%h of=%0d un=%0d err=%0d zero=%0d lat=%0d (exp out=%h lat=%0d)",
             o, xa, xb, dout, of, un, err, zero, lat, r, e_lat);
    for (int h = 0; h <= hold; h++) begin
      chk("out", dout, r);
      chk("of", of, e_of);
      chk("un", un, e_un);
      chk("err", err, e_err);
      chk("zero", zero, int'(r == 0 && e_err == 0));
      chk("out_valid_held", out_valid, 1);
      chk("in_ready_in_done", in_ready, 0);
      if (h == hold) begin out_ready = 1'b1; in_valid = 1'b0; end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_valid_dropped", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_out", dout, 0);
    chk("rst_flags", {of, un, err, zero}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_op(4'h0, 8'hF0, 8'h20, 0);
    run_op(4'h1, 8'h02, 8'h03, 0);
    run_op(4'h7, 8'h10, 8'h11, 1);
    run_op(4'h8, 8'd100, 8'd7, 0);
    run_op(4'h8, 8'd55, 8'd0, 0);
    run_op(4'h9, 8'd100, 8'd7, 0);
    run_op(4'h9, 8'd100, 8'd0, 0);
    run_op(4'h4, 8'h5A, 8'h5A, 5);
    run_op(4'hF, 8'h12, 8'h34, 0);
    run_op(4'h5, 8'h81, 8'd1, 0);
    run_op(4'h5, 8'h81, 8'd9, 0);
    run_op(4'h6, 8'hFF, 8'd8, 0);
    run_op(4'h0, 8'h33, 8'h44, 0);

    // Abort a MUL with an asynchronous reset in its fourth cycle
    @(negedge clk);
    in_valid = 1'b1; op = 4'h7; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mul_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", dout, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("no_stale_result", lat, 0);
    run_op(4'h0, 8'd3, 8'd4, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU. Operand width is generic.
- Adds multi-cycle multiply and divide and a valid/ready handshake on both sides.
- Keeps the existing flag set: of, un, err, zero.
- Sits between the operand register file and the result writeback in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- SHW, $clog2(WIDTH), derived width of the shift-amount field taken from b.

Ports:
- clk  in  1  single system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op  in  4  operation code.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- of  out  1  overflow.
- un  out  1  underflow (borrow).
- err  out  1  illegal op or divide by zero.
- zero  out  1  out == 0 while out_valid is high.
- busy  out  1  a multi-cycle operation is in progress.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE. out, of, un, err, zero and out_valid all go to 0; busy=0; in_ready=1. Reset mid-operation aborts the operation and drops any pending result.
- States: IDLE, ITER, DONE.
- in_ready is 1 only in IDLE. An operation is accepted when in_valid && in_ready; a, b and op are captured on that edge.
- Single-cycle ops, accepted in IDLE, go to DONE. out_valid=1 the cycle after acceptance, so latency is 1.
  - 0000 ADD: out = a+b mod 2^WIDTH; of = carry out.
  - 0001 SUB: out = a-b mod 2^WIDTH; un = (a<b).
  - 0010 AND, 0011 OR, 0100 XOR: bitwise.
  - 0101 SHL: out = a << b[SHW-1:0]; of = 1 if any 1 bit is shifted out. If b >= WIDTH: out=0 and of = (a!=0).
  - 0110 SHR: logical right shift; of=0. If b >= WIDTH: out=0.
- Multi-cycle ops go IDLE -> ITER. Exactly WIDTH iterations, then DONE. out_valid rises WIDTH+1 cycles after acceptance. busy=1 in ITER.
  - 0111 MUL: shift-add; out = low WIDTH bits of the product; of = (high WIDTH bits != 0).
  - 1000 DIV: restoring division; out = quotient.
  - DIV with b==0: skip ITER and go straight to DONE (latency 1); out = all ones, err=1.
- Any other op: go to DONE with latency 1; out=0, err=1, zero=0.
- Flags not defined for an op are 0. zero = (out==0) && !err.
- DONE: hold out and all flags stable until out_ready. On out_valid && out_ready, go to IDLE and drop out_valid the next cycle. in_ready returns to 1 in that next cycle, so there is no same-cycle re-accept.
- in_valid while not in_ready is ignored; the producer must hold its request.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro ALU_SEQ_REM_EN.
- Defined: op 1001 REM is multi-cycle (WIDTH iterations) and returns the remainder from the shared divider. With b==0: out=a, err=1, latency 1.
- Undefined: 1001 is illegal; latency 1, out=0, err=1.

Decomposition:
- Package alu_pkg:
  - op code localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_DIV, OP_REM;
  - state enum: IDLE, ITER, DONE.
- Sub-module alu_seq_iter: shift-add/restoring-divide datapath with a WIDTH-step counter, start/done pulses, and quotient, remainder and product-high outputs.
- The top-level alu_seq holds the FSM, the single-cycle ops and the output registers.

Test Plan (WIDTH=8):
- ADD: a=0xF0, b=0x20, out_ready=1 -> one cycle later out=0x10, of=1, zero=0. SUB: a=0x02, b=0x03 -> out=0xFF, un=1.
- MUL: a=0x10, b=0x11 -> out_valid exactly 9 cycles after acceptance; out=0x10, of=1; busy=1 for 8 cycles; in_ready=0 throughout.
- DIV: a=100, b=7 -> out=14 after 9 cycles. DIV with b=0 -> out=0xFF, err=1, latency 1. With ALU_SEQ_REM_EN, REM a=100, b=7 -> out=2.
- Backpressure: XOR with a=b=0x5A and out_ready=0 for 5 cycles -> out=0, zero=1, all held stable and in_ready=0; after out_ready pulses, in_ready=1 the next cycle.
- Illegal op 1111 -> err=1, out=0, zero=0. SHL a=0x81, b=1 -> out=0x02, of=1. SHL with b=9 -> out=0, of=1.
- Assert rst during cycle 4 of a MUL -> outputs clear asynchronously; in_ready=1 after release; the next ADD 3+4 gives out=7.
